// File: rtl/odu_wrr_sel_data_if.sv
// FIFO-array side and output-stream side of the ODU weighted round-robin selector.
// master = selector, slave = FIFO array plus downstream consumer.
interface odu_wrr_sel_data_if #(
    parameter int unsigned NUM_CH     = 80,
    parameter int unsigned DATA_WIDTH = 387,
    parameter int unsigned CHID_WIDTH = 7
);
    logic [NUM_CH-1:0]            fifo_empty;
    logic [NUM_CH*DATA_WIDTH-1:0] fifo_data;
    logic [NUM_CH-1:0]            fifo_read_enable;
    logic [DATA_WIDTH-1:0]        data_out;
    logic [CHID_WIDTH-1:0]        chid_out;
    logic                         data_valid;
    logic                         out_ready;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_read_enable, data_out, chid_out, data_valid
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_read_enable, data_out, chid_out, data_valid
    );
endinterface

// File: rtl/odu_wrr_sel_data.sv
// Weighted round-robin selector over NUM_CH FIFOs: one pop per grant, word presented
// with its channel ID on a valid/ready output. Weight = words served per turn (0 acts as 1).
module odu_wrr_sel_data #(
    parameter int unsigned NUM_CH       = 80,
    parameter int unsigned DATA_WIDTH   = 387,
    parameter int unsigned CHID_WIDTH   = 7,
    parameter int unsigned WEIGHT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CH-1:0]              enable_chid,
    input  logic [NUM_CH*WEIGHT_WIDTH-1:0] weight_chid,
    odu_wrr_sel_data_if.master             bus
);
    localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] ARB  = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CHID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CHID_WIDTH-1:0]   cur_q, cur_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CHID_WIDTH-1:0]   chid_q, chid_d;
    logic                    valid_q, valid_d;

    logic [NUM_CH-1:0]       elig;
    logic [NUM_CH-1:0]       rd_en;
    logic [CHID_WIDTH-1:0]   base;
    logic [CHID_WIDTH-1:0]   srch;
    logic [CHID_WIDTH-1:0]   grant;
    logic [WEIGHT_WIDTH-1:0] srch_w;
    logic [DATA_WIDTH-1:0]   cur_data;

    function automatic logic [CHID_WIDTH-1:0] wrap_inc(input logic [CHID_WIDTH-1:0] i);
        return (32'(i) == NUM_CH - 1) ? '0 : i + 1'b1;
    endfunction

    assign elig = enable_chid & ~bus.fifo_empty;

    // An unfinished turn whose channel went ineligible restarts the search just past it.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        base  = (credit_q != '0) ? wrap_inc(cur_q) : rr_ptr_q;
        srch  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = 32'(base) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && elig[IW'(idx)]) begin
                found = 1'b1;
                srch  = CHID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        srch_w   = '0;
        cur_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(srch) == i)  srch_w   = weight_chid[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            if (32'(cur_q) == i) cur_data = bus.fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        data_d   = data_q;
        chid_d   = chid_q;
        valid_d  = valid_q;
        grant    = '0;
        rd_en    = '0;
        case (state_q)
            ARB: begin
                if (start && (|elig)) begin
                    if ((credit_q != '0) && elig[IW'(cur_q)]) begin
                        grant = cur_q;
                    end else begin
                        grant    = srch;
                        cur_d    = srch;
                        credit_d = (srch_w == '0) ? WEIGHT_WIDTH'(1) : srch_w;
                        if (credit_q != '0) rr_ptr_d = base;
                    end
                    rd_en[IW'(grant)] = 1'b1;
                    state_d = RD;
                end
            end
            RD: begin
                data_d   = cur_data;
                chid_d   = cur_q;
                valid_d  = 1'b1;
                credit_d = credit_q - 1'b1;
                if (credit_q == WEIGHT_WIDTH'(1)) rr_ptr_d = wrap_inc(cur_q);
                state_d = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            cur_q    <= '0;
            credit_q <= '0;
            data_q   <= '0;
            chid_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
            data_q   <= data_d;
            chid_q   <= chid_d;
            valid_q  <= valid_d;
        end
    end

    // Read pulse is combinational from ARB; masked so no FIFO pops while reset is held.
    assign bus.fifo_read_enable = rst ? rd_en : '0;
    assign bus.data_out         = data_q;
    assign bus.chid_out         = chid_q;
    assign bus.data_valid       = valid_q;
endmodule
